// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scan driver: blank pattern and
// active-low {g,f,e,d,c,b,a} hex glyph table.
package seven_seg_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Element 15 (F) first, element 0 (0) last.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational nibble-to-glyph decoder for one common-anode digit.
module hex_to_7seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] NIBBLE,
    output logic [6:0] SEG
);

    always_comb begin
        SEG = hex_to_seg(NIBBLE);
    end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed 8-digit hex display driver with frame-synchronous update.
// Optional leading-zero blanking is enabled by defining SEVENSEG_LZ_BLANK_EN.
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int unsigned N_DIGITS = 8,
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [4*N_DIGITS-1:0] SEVENSEGHEX,
    input  logic                  HEX_VALID,
    output logic [N_DIGITS-1:0]   ANODE,
    output logic [6:0]            CATHODE,
    output logic                  DP,
    output logic                  FRAME_DONE
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic [DIV_W-1:0]      div_cnt, div_nxt;
    logic [IDX_W-1:0]      idx, idx_nxt;
    logic [4*N_DIGITS-1:0] shown, shown_nxt, pending;
    logic                  pend_vld;
    logic                  tc, last, fb;
    logic [3:0]            nib;
    logic [6:0]            seg;
    logic [N_DIGITS-1:0]   anode_nxt;
    logic                  lz_blank;
`ifdef SEVENSEG_LZ_BLANK_EN
    logic [IDX_W-1:0]      msd;
`endif

    always_comb begin
        tc      = (div_cnt == DIV_W'(SCAN_DIV - 1));
        last    = (idx == IDX_W'(N_DIGITS - 1));
        fb      = tc && last;
        div_nxt = tc ? '0 : div_cnt + DIV_W'(1);
        idx_nxt = !tc ? idx : (last ? '0 : idx + IDX_W'(1));

        // A strobe coinciding with the frame boundary bypasses the pending register.
        shown_nxt = shown;
        if (fb) begin
            if (HEX_VALID)
                shown_nxt = SEVENSEGHEX;
            else if (pend_vld)
                shown_nxt = pending;
        end

        nib       = '0;
        anode_nxt = '1;
        for (int unsigned k = 0; k < N_DIGITS; k++) begin
            if (IDX_W'(k) == idx_nxt) begin
                nib          = shown_nxt[4*k +: 4];
                anode_nxt[k] = 1'b0;
            end
        end

`ifdef SEVENSEG_LZ_BLANK_EN
        msd = '0;
        for (int unsigned k = 1; k < N_DIGITS; k++) begin
            if (shown_nxt[4*k +: 4] != 4'h0)
                msd = IDX_W'(k);
        end
        lz_blank = (idx_nxt > msd);
`else
        lz_blank = 1'b0;
`endif
    end

    hex_to_7seg u_hex_to_7seg (
        .NIBBLE (nib),
        .SEG    (seg)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            div_cnt    <= '0;
            idx        <= '0;
            shown      <= '0;
            pending    <= '0;
            pend_vld   <= 1'b0;
            ANODE      <= '1;
            CATHODE    <= SEG_OFF;
            DP         <= 1'b1;
            FRAME_DONE <= 1'b0;
        end else begin
            div_cnt    <= div_nxt;
            idx        <= idx_nxt;
            shown      <= shown_nxt;
            if (HEX_VALID)
                pending <= SEVENSEGHEX;
            if (fb)
                pend_vld <= 1'b0;
            else if (HEX_VALID)
                pend_vld <= 1'b1;
            FRAME_DONE <= fb;
            DP         <= 1'b1;
            // First cycle of each digit slot is blanked to suppress ghosting.
            if (div_nxt == '0) begin
                ANODE   <= '1;
                CATHODE <= SEG_OFF;
            end else begin
                ANODE   <= anode_nxt;
                CATHODE <= lz_blank ? SEG_OFF : seg;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Randomized self-checking bench for seven_seg_scan_driver (SCAN_DIV=4, N_DIGITS=8);
// honours SEVENSEG_LZ_BLANK_EN in its reference model.
module tb_seven_seg_scan_driver;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] SEVENSEGHEX = '0;
    logic        HEX_VALID = 1'b0;
    logic [7:0]  ANODE;
    logic [6:0]  CATHODE;
    logic        DP;
    logic        FRAME_DONE;

    int total = 0;
    int bad   = 0;
    bit checking = 0;

    // Reference state: cycles since reset plus the value on the display.
    int          t = 0;
    logic [31:0] m_shown = '0, m_pend = '0;
    bit          m_pv = 0, m_rst = 1, m_fd = 0;

    logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seven_seg_scan_driver #(.N_DIGITS(8), .SCAN_DIV(4)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .SEVENSEGHEX (SEVENSEGHEX),
        .HEX_VALID   (HEX_VALID),
        .ANODE       (ANODE),
        .CATHODE     (CATHODE),
        .DP          (DP),
        .FRAME_DONE  (FRAME_DONE)
    );

    always #5 CLK = ~CLK;

    function automatic void expected(output logic [7:0] a, output logic [6:0] c);
        int idx, msd;
        logic [3:0] n;
        a = 8'hFF;
        c = 7'h7F;
        if (!m_rst && (t % 4) != 0) begin
            idx = (t / 4) % 8;
            a   = 8'hFF & ~(8'h01 << idx);
            n   = 4'((m_shown >> (4 * idx)) & 32'hF);
            c   = tbl[n];
`ifdef SEVENSEG_LZ_BLANK_EN
            msd = 0;
            for (int k = 1; k < 8; k++)
                if (((m_shown >> (4 * k)) & 32'hF) != 0) msd = k;
            if (idx > msd) c = 7'h7F;
`endif
        end
    endfunction

    always @(posedge CLK) begin
        bit fb;
        logic [7:0] ea;
        logic [6:0] ec;
        int zeros;
        if (RESET) begin
            t = 0; m_shown = '0; m_pend = '0; m_pv = 0; m_rst = 1; m_fd = 0;
        end else begin
            fb   = (t % 32) == 31;
            m_fd = fb;
            if (HEX_VALID && fb)       m_shown = SEVENSEGHEX;
            else if (HEX_VALID)        begin m_pend = SEVENSEGHEX; m_pv = 1; end
            else if (fb && m_pv)       m_shown = m_pend;
            if (fb) m_pv = 0;
            t++;
            m_rst = 0;
        end
        #1;
        if (checking) begin
            expected(ea, ec);
            zeros = 0;
            for (int k = 0; k < 8; k++) if (!ANODE[k]) zeros++;
            total++;
            if (ANODE !== ea || CATHODE !== ec || DP !== 1'b1 || FRAME_DONE !== m_fd || zeros > 1) begin
                bad++;
                $display("FAIL cycle t=%0d: got ANODE=%h CATHODE=%h DP=%b FD=%b, want ANODE=%h CATHODE=%h DP=1 FD=%b",
                         t, ANODE, CATHODE, DP, FRAME_DONE, ea, ec, m_fd);
            end
        end
    end

    task automatic cyc(input bit rst, input bit hv, input logic [31:0] val);
        @(negedge CLK);
        RESET = rst; HEX_VALID = hv; SEVENSEGHEX = val;
        @(posedge CLK);
        #2;
    endtask

    task automatic run_to(input int pos);
        int n = 0;
        do begin
            cyc(0, 0, '0);
            n++;
        end while ((t % 32) != pos && n < 64);
        if ((t % 32) != pos) begin
            total++; bad++;
            $display("FAIL run_to: position %0d not reached, at %0d", pos, t % 32);
        end
    endtask

    task automatic lit(input string name, input logic [7:0] a, input logic [6:0] c);
        total++;
        if (ANODE !== a || CATHODE !== c) begin
            bad++;
            $display("FAIL %s: got ANODE=%h CATHODE=%h, want ANODE=%h CATHODE=%h", name, ANODE, CATHODE, a, c);
        end
    endtask

    initial begin
        logic [31:0] v;
        cyc(1, 0, '0);
        checking = 1;
        cyc(1, 0, '0);
        lit("reset_state", 8'hFF, 7'h7F);
        cyc(0, 0, '0);
        lit("digit0_after_reset", 8'hFE, 7'h40);
        run_to(4);
        lit("blank_slot1", 8'hFF, 7'h7F);
        run_to(31);
        cyc(0, 0, '0);
        total++;
        if (FRAME_DONE !== 1'b1) begin
            bad++; $display("FAIL frame_done_32: got %b want 1", FRAME_DONE);
        end

        // Strobe mid-frame: old value held until the frame boundary.
        run_to(10);
        cyc(0, 1, 32'h0123ABCF);
        run_to(17);
        lit("hold_old_digit4", 8'hEF, 7'h40);
        run_to(1);
        lit("new_digit0_F", 8'hFE, 7'h0E);
        run_to(5);
        lit("new_digit1_C", 8'hFD, 7'h46);
        run_to(29);
`ifdef SEVENSEG_LZ_BLANK_EN
        lit("new_digit7_lz", 8'h7F, 7'h7F);
`else
        lit("new_digit7_0", 8'h7F, 7'h40);
`endif

        // Two strobes in one frame: last wins.
        run_to(5);
        cyc(0, 1, 32'h11111111);
        run_to(20);
        cyc(0, 1, 32'h88888888);
        run_to(1);
        lit("last_wins_d0", 8'hFE, 7'h00);
        run_to(13);
        lit("last_wins_d3", 8'hF7, 7'h00);

        // Strobe exactly on the frame boundary.
        run_to(31);
        cyc(0, 1, 32'h00000009);
        lit("fb_bypass_blank", 8'hFF, 7'h7F);
        run_to(1);
        lit("fb_bypass_d0", 8'hFE, 7'h10);

        // Randomized traffic including occasional resets.
        for (int i = 0; i < 800; i++) begin
            v = $urandom;
            if ($urandom_range(1, 0) == 1) v = v >> $urandom_range(31, 0);
            cyc($urandom_range(299, 0) == 0, $urandom_range(11, 0) == 0, v);
        end

        // Small value, then reset with a pending value outstanding.
        cyc(1, 0, '0);
        cyc(0, 1, 32'h000000A5);
        run_to(1);
        lit("a5_d0", 8'hFE, 7'h12);
        run_to(5);
        lit("a5_d1", 8'hFD, 7'h08);
        run_to(9);
`ifdef SEVENSEG_LZ_BLANK_EN
        lit("a5_d2_lz", 8'hFB, 7'h7F);
`else
        lit("a5_d2", 8'hFB, 7'h40);
`endif
        cyc(0, 1, 32'hFFFFFFFF);
        run_to(20);
        cyc(1, 0, '0);
        lit("mid_reset", 8'hFF, 7'h7F);
        run_to(31);
        cyc(0, 0, '0);
        run_to(1);
        lit("pending_discarded", 8'hFE, 7'h40);
        run_to(10);

        checking = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
